// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the floating-point multiplier arbiter.
// Contents: FSM state encoding, the quiet-NaN pattern returned on a multiplier
// timeout, and the grant-index width helper.
package fp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Bits needed to hold a requester index (at least one bit).
    function automatic int unsigned grant_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first asserted request scanning upward
// from last_grant+1 with wrap-around.
// Ports: req (request vector), last_grant (index granted last),
//        grant (one-hot winner), grant_idx (winner index), any (some request set).
module rr_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned GW = grant_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [GW-1:0] grant_idx,
    output logic          any
);

    int unsigned idx;

    // Scan offsets 1..N after last_grant; the nearest requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last_grant) + k) % N;
            if (!any && req[GW'(idx)]) begin
                any            = 1'b1;
                grant[GW'(idx)] = 1'b1;
                grant_idx      = GW'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one floating-point multiplier among N_REQ requesters with round-robin
// arbitration; one multiply in flight, result returned only to the grant holder.
// Optional feature: define FP_ARB_TIMEOUT_EN to abort a WAIT that exceeds
// TIMEOUT_CYC cycles, answering qNaN with rsp_err=1.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake (ready one-hot, IDLE only)
//   req_a, req_b, req_rnd              packed per-requester operands / round mode
//   rsp_valid/rsp_ready                response handshake (valid one-hot)
//   rsp_data, rsp_err                  shared product and timeout flag
//   busy                               FSM not in IDLE
//   mul_start, mul_a, mul_b,
//   mul_round_mode                     multiplier command (start is a one-cycle pulse)
//   mul_result, mul_done               multiplier return (done sampled only in WAIT)
module fp_mul_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned D_LEN       = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*D_LEN-1:0] req_a,
    input  logic [N_REQ*D_LEN-1:0] req_b,
    input  logic [N_REQ*2-1:0]     req_rnd,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [D_LEN-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [D_LEN-1:0]       mul_a,
    output logic [D_LEN-1:0]       mul_b,
    output logic [1:0]             mul_round_mode,
    input  logic [D_LEN-1:0]       mul_result,
    input  logic                   mul_done
);

    localparam int unsigned GW = grant_w(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("fp_mul_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
    end

    state_t             state, state_nxt;
    logic [GW-1:0]      last_grant, grant_id, arb_idx;
    logic [N_REQ-1:0]   arb_grant;
    logic               arb_any, accept;
    logic [D_LEN-1:0]   sel_a, sel_b;
    logic [1:0]         sel_rnd;

    rr_arbiter #(.N(N_REQ), .GW(GW)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .any        (arb_any)
    );

    // Operand mux for the arbitration winner.
    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_rnd = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (GW'(i) == arb_idx) begin
                sel_a   = req_a[i*D_LEN +: D_LEN];
                sel_b   = req_b[i*D_LEN +: D_LEN];
                sel_rnd = req_rnd[2*i +: 2];
            end
        end
    end

`ifdef FP_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout;

    // Fires on the TIMEOUT_CYC-th WAIT cycle that still has no done.
    assign timeout = (state == WAIT) && !mul_done && (wait_cnt == CW'(TIMEOUT_CYC - 1));

    // WAIT cycle counter; zero whenever the FSM is outside WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + CW'(1) : '0;
            if (timeout) begin
                rsp_err <= 1'b1;
            end else if (state == RESP && state_nxt == IDLE) begin
                rsp_err <= 1'b0;
            end
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

    // Next-state and request accept.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                req_ready = arb_grant;
                if (arb_any) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (mul_done) begin
                    state_nxt = RESP;
                end
`ifdef FP_ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_nxt = RESP;
                end
`endif
            end
            RESP: begin
                if (rsp_ready[grant_id]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, operand latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= GW'(N_REQ - 1);
            grant_id       <= '0;
            mul_a          <= '0;
            mul_b          <= '0;
            mul_round_mode <= '0;
            mul_start      <= 1'b0;
            busy           <= 1'b0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
        end else begin
            state     <= state_nxt;
            mul_start <= (state_nxt == ISSUE);
            busy      <= (state_nxt != IDLE);
            rsp_valid <= (state_nxt == RESP) ? (N_REQ'(1) << grant_id) : '0;
            if (accept) begin
                mul_a          <= sel_a;
                mul_b          <= sel_b;
                mul_round_mode <= sel_rnd;
                grant_id       <= arb_idx;
            end
            if (state == WAIT && mul_done) begin
                rsp_data <= mul_result;
            end
`ifdef FP_ARB_TIMEOUT_EN
            else if (timeout) begin
                rsp_data <= D_LEN'(FP_QNAN);
            end
`endif
            if (state == RESP && state_nxt == IDLE) begin
                last_grant <= grant_id;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter: table-driven single transactions
// plus directed sequences for arbitration order, backpressure, reset and timeout.
module tb_fp_mul_arbiter;

    localparam int N = 4;
    localparam int D = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*D-1:0]   req_a, req_b;
    logic [2*N-1:0]   req_rnd;
    logic [D-1:0]     rsp_data, mul_a, mul_b, mul_result;
    logic             rsp_err, busy, mul_start, mul_done;
    logic [1:0]       mul_round_mode;

    always #5 clk = ~clk;

    fp_mul_arbiter #(.N_REQ(N), .D_LEN(D), .TIMEOUT_CYC(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_rnd        (req_rnd),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .mul_start      (mul_start),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_round_mode (mul_round_mode),
        .mul_result     (mul_result),
        .mul_done       (mul_done)
    );

    typedef struct {
        int          req;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        int          lat;
        logic [31:0] prod;
    } vec_t;

    int n_cmp = 0;
    int n_fail = 0;

    int          cyc, acc_cyc, start_cyc, done_cyc, start_cnt;
    int          mul_lat, mul_cnt;
    logic        mul_busy, mul_en;
    logic [31:0] op_a, op_b;
    logic [1:0]  op_rnd;
    logic [N-1:0] rereq;
    int          grant_q[$];
    int          rsp_idx_q[$];
    logic [31:0] rsp_dat_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Hand-computed IEEE-754 single products used by the multiplier model.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            64'h3F800000_40000000: return 32'h40000000;
            64'h40000000_40400000: return 32'h40C00000;
            64'h3FC00000_3FC00000: return 32'h40100000;
            64'hC0000000_40400000: return 32'hC0C00000;
            64'h40400000_40400000: return 32'h41100000;
            64'h3F000000_40800000: return 32'h40000000;
            64'h40800000_40800000: return 32'h41800000;
            default:               return 32'hDEADBEEF;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] r);
        req_a[i*D +: D]   = a;
        req_b[i*D +: D]   = b;
        req_rnd[2*i +: 2] = r;
        req_valid[i]      = 1'b1;
    endtask

    task automatic clear_logs();
        grant_q.delete();
        rsp_idx_q.delete();
        rsp_dat_q.delete();
    endtask

    // One clock: sample handshakes at negedge, update requesters and multiplier model after posedge.
    task automatic tick();
        logic [N-1:0] hs, rh;
        logic st;
        @(negedge clk);
        hs = req_valid & req_ready;
        rh = rsp_valid & rsp_ready;
        st = mul_start;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                grant_q.push_back(i);
                acc_cyc = cyc;
            end
            if (rh[i]) begin
                rsp_idx_q.push_back(i);
                rsp_dat_q.push_back(rsp_data);
            end
        end
        if (st) begin
            start_cnt++;
            start_cyc = cyc;
            op_a      = mul_a;
            op_b      = mul_b;
            op_rnd    = mul_round_mode;
        end
        @(posedge clk);
        #1;
        cyc++;
        req_valid = req_valid & ~(hs & ~rereq);
        mul_done  = 1'b0;
        if (st) begin
            mul_busy = 1'b1;
            mul_cnt  = mul_lat;
        end
        if (mul_busy && mul_en) begin
            if (mul_cnt == 0) begin
                mul_done   = 1'b1;
                mul_result = fmul(op_a, op_b);
                mul_busy   = 1'b0;
                done_cyc   = cyc;
            end else begin
                mul_cnt--;
            end
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        mul_done  = 1'b0;
        mul_busy  = 1'b0;
        mul_en    = 1'b1;
        rereq     = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    // Full transaction for one requester with rsp_ready held high.
    task automatic run_one(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] r, input int lat, input logic [31:0] exp);
        int k;
        int n0;
        n0 = rsp_dat_q.size();
        mul_lat   = lat;
        rsp_ready = '1;
        set_req(i, a, b, r);
        k = 0;
        while (rsp_dat_q.size() == n0 && k < 100) begin
            tick();
            k++;
        end
        chk("run_one_rsp_seen", 64'(rsp_dat_q.size() > n0), 64'd1);
        if (rsp_dat_q.size() > n0) begin
            chk("run_one_data", rsp_dat_q[$], exp);
            chk("run_one_idx", rsp_idx_q[$], i);
        end
        rsp_ready = '0;
    endtask

    vec_t        vecs[4];
    logic [31:0] exp2[4];
    int          k;
    logic [31:0] held;

    initial begin
        cyc = 0; acc_cyc = 0; start_cyc = 0; done_cyc = 0; start_cnt = 0;
        mul_lat = 0; mul_cnt = 0; mul_result = '0;
        op_a = '0; op_b = '0; op_rnd = '0;
        req_a = '0; req_b = '0; req_rnd = '0;

        vecs[0] = '{req: 0, a: 32'h3F800000, b: 32'h40000000, rnd: 2'd0, lat: 0, prod: 32'h40000000};
        vecs[1] = '{req: 2, a: 32'h40000000, b: 32'h40400000, rnd: 2'd1, lat: 3, prod: 32'h40C00000};
        vecs[2] = '{req: 3, a: 32'h3FC00000, b: 32'h3FC00000, rnd: 2'd2, lat: 1, prod: 32'h40100000};
        vecs[3] = '{req: 1, a: 32'hC0000000, b: 32'h40400000, rnd: 2'd3, lat: 5, prod: 32'hC0C00000};
        exp2 = '{32'h40000000, 32'h40C00000, 32'h41100000, 32'h41800000};

        // Reset state
        do_reset();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_mul_start", 64'(mul_start), 64'd0);
        chk("reset_mul_a", 64'(mul_a), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_err", 64'(rsp_err), 64'd0);

        // Table-driven single transactions
        for (int v = 0; v < 4; v++) begin
            start_cnt = 0;
            mul_lat   = vecs[v].lat;
            rsp_ready = '0;
            set_req(vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].rnd);
            k = 0;
            while (rsp_valid == '0 && k < 100) begin
                tick();
                k++;
            end
            chk("vec_rsp_valid", 64'(rsp_valid), 64'(4'(1) << vecs[v].req));
            chk("vec_rsp_data", 64'(rsp_data), 64'(vecs[v].prod));
            chk("vec_mul_a", 64'(op_a), 64'(vecs[v].a));
            chk("vec_mul_b", 64'(op_b), 64'(vecs[v].b));
            chk("vec_mul_rnd", 64'(op_rnd), 64'(vecs[v].rnd));
            chk("vec_mul_a_held", 64'(mul_a), 64'(vecs[v].a));
            chk("vec_start_pulses", 64'(start_cnt), 64'd1);
            chk("vec_start_latency", 64'(start_cyc - acc_cyc), 64'd1);
            chk("vec_rsp_latency", 64'(cyc - done_cyc), 64'd1);
            chk("vec_grant", 64'((grant_q.size() > 0) ? grant_q[$] : -1), 64'(vecs[v].req));
            chk("vec_busy", 64'(busy), 64'd1);
            rsp_ready = '1;
            tick();
            chk("vec_idle_busy", 64'(busy), 64'd0);
            chk("vec_idle_rsp_valid", 64'(rsp_valid), 64'd0);
            rsp_ready = '0;
        end

        // All four request together, rsp_ready tied high
        do_reset();
        mul_lat = 2;
        set_req(0, 32'h3F800000, 32'h40000000, 2'd0);
        set_req(1, 32'h40000000, 32'h40400000, 2'd0);
        set_req(2, 32'h40400000, 32'h40400000, 2'd0);
        set_req(3, 32'h40800000, 32'h40800000, 2'd0);
        rsp_ready = '1;
        k = 0;
        while (rsp_dat_q.size() < 4 && k < 200) begin
            tick();
            k++;
        end
        chk("all4_rsp_count", 64'(rsp_dat_q.size()), 64'd4);
        for (int j = 0; j < 4 && j < rsp_dat_q.size() && j < grant_q.size(); j++) begin
            chk("all4_grant", 64'(grant_q[j]), 64'(j));
            chk("all4_rsp_idx", 64'(rsp_idx_q[j]), 64'(j));
            chk("all4_rsp_data", 64'(rsp_dat_q[j]), 64'(exp2[j]));
        end

        // Continuous re-requests from req0 and req1 alternate
        do_reset();
        mul_lat = 1;
        rereq   = 4'b0011;
        set_req(0, 32'h3FC00000, 32'h3FC00000, 2'd0);
        set_req(1, 32'h3F000000, 32'h40800000, 2'd1);
        rsp_ready = '1;
        k = 0;
        while (grant_q.size() < 4 && k < 200) begin
            tick();
            k++;
        end
        rereq     = '0;
        req_valid = '0;
        k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        chk("alt_grant_count", 64'(grant_q.size()), 64'd4);
        for (int j = 0; j < 4 && j < grant_q.size(); j++) begin
            chk("alt_grant", 64'(grant_q[j]), 64'(j % 2));
        end
        for (int j = 0; j < 4 && j < rsp_dat_q.size(); j++) begin
            chk("alt_rsp_data", 64'(rsp_dat_q[j]), 64'((j % 2 == 0) ? 32'h40100000 : 32'h40000000));
        end

        // Backpressure on req0's response
        clear_logs();
        rsp_ready = '0;
        mul_lat   = 1;
        set_req(0, 32'h40400000, 32'h40400000, 2'd0);
        k = 0;
        while (rsp_valid == '0 && k < 50) begin
            tick();
            k++;
        end
        held = rsp_data;
        chk("bp_first_data", 64'(held), 64'h41100000);
        set_req(2, 32'h40800000, 32'h40800000, 2'd2);
        rsp_ready = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_rsp_valid", 64'(rsp_valid), 64'h1);
            chk("bp_rsp_data", 64'(rsp_data), 64'(held));
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
        end
        chk("bp_no_rsp_taken", 64'(rsp_dat_q.size()), 64'd0);
        rsp_ready = '1;
        k = 0;
        while (rsp_dat_q.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("bp_rsp_count", 64'(rsp_dat_q.size()), 64'd2);
        if (rsp_dat_q.size() >= 2) begin
            chk("bp_second_idx", 64'(rsp_idx_q[1]), 64'd2);
            chk("bp_second_data", 64'(rsp_dat_q[1]), 64'h41800000);
        end
        rsp_ready = '0;

        // Reset during WAIT
        clear_logs();
        run_one(1, 32'h40000000, 32'h40400000, 2'd1, 0, 32'h40C00000);
        mul_lat   = 20;
        rsp_ready = '1;
        set_req(0, 32'h3F800000, 32'h40000000, 2'd0);
        k = 0;
        while (!mul_busy && k < 20) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk("rst_pre_busy", 64'(busy), 64'd1);
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_mul_ab", {mul_a, mul_b}, 64'd0);
        chk("rst_mul_rnd", 64'(mul_round_mode), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        clear_logs();
        k = 0;
        while (mul_busy && k < 40) begin
            tick();
            k++;
        end
        repeat (2) tick();
        chk("late_done_busy", 64'(busy), 64'd0);
        chk("late_done_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("late_done_no_rsp", 64'(rsp_dat_q.size()), 64'd0);
        mul_lat = 0;
        set_req(0, 32'h3F800000, 32'h40000000, 2'd0);
        set_req(2, 32'h40000000, 32'h40400000, 2'd0);
        k = 0;
        while (rsp_dat_q.size() < 2 && k < 50) begin
            tick();
            k++;
        end
        chk("post_rst_grant_count", 64'(grant_q.size()), 64'd2);
        if (grant_q.size() >= 2) begin
            chk("post_rst_first", 64'(grant_q[0]), 64'd0);
            chk("post_rst_second", 64'(grant_q[1]), 64'd2);
        end
        rsp_ready = '0;

        // Multiplier never answers
        do_reset();
        mul_en    = 1'b0;
        rsp_ready = '1;
        set_req(0, 32'h3F800000, 32'h40000000, 2'd0);
`ifdef FP_ARB_TIMEOUT_EN
        k = 0;
        while (rsp_valid == '0 && k < 200) begin
            tick();
            k++;
        end
        chk("to_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("to_rsp_err", 64'(rsp_err), 64'd1);
        chk("to_rsp_data", 64'(rsp_data), 64'h7FC00000);
        chk("to_wait_len", 64'(cyc - start_cyc), 64'd65);
        tick();
        chk("to_err_clear", 64'(rsp_err), 64'd0);
        chk("to_idle", 64'(busy), 64'd0);
`else
        repeat (100) tick();
        chk("nto_busy", 64'(busy), 64'd1);
        chk("nto_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("nto_rsp_err", 64'(rsp_err), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
